display_driver: RTL and testbench
=================================

// Module: display_driver
// PURPOSE
//  Raster timing generator and pixel output stage for the 640x400 micro-display.
//  Scans the frame buffer linearly and drives rd_addr. The frame buffer returns a 4-bit index to color_table.
//  color_table returns a 10-bit {Y,Cr,Cb} code, and this block drives it to the panel pins with aligned hsync/vsync.
//  Starts scanning only after the frame buffer reports ready.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line;  H_FRONT 24;  H_SYNC 32;  H_BACK 104  (H_TOTAL 800)
//  V_ACTIVE 400  visible lines/frame;  V_FRONT 4;   V_SYNC 4;   V_BACK 12   (V_TOTAL 420)
//  RD_LATENCY 2  clocks from rd_addr to matching color (fb read + color_table read)
//  SYNC_ACT_LOW 1  1 = hsync/vsync active-low
// PORTS
//  clk        in   1   display_clk
//  reset_n    in   1   reset_n_byte, asynchronous, active-low
//  ready      in   1   frame buffer initialised; gates scan start
//  color      in   10  {y[3:0],cr[2:0],cb[2:0]} from color_table, RD_LATENCY after rd_addr
//  rd_addr    out  18  frame-buffer pixel address, row*640+col
//  clock_out  out  1   pixel clock forwarded to panel
//  hsync      out  1   line sync
//  vsync      out  1   frame sync
//  y          out  4   luma
//  cr         out  3   red chroma
//  cb         out  3   blue chroma
// BEHAVIOUR
//  Reset (async, reset_n=0), all outputs at inactive level:
//   h_cnt=v_cnt=0, running=0, rd_addr=0, y/cr/cb=0, hsync=vsync=inactive (1 when SYNC_ACT_LOW), clock_out=0.
//  Start: running sets on the first clk edge with ready=1 and stays set until the frame boundary after ready drops.
//   First running cycle is h_cnt=0, v_cnt=0.
//  Counters:
//   h_cnt 0..H_TOTAL-1, wraps to 0 and advances v_cnt.
//   v_cnt 0..V_TOTAL-1, wraps to 0 (frame boundary).
//  Horizontal regions: active 0..639, front 640..663, sync 664..695, back 696..799.
//  Vertical regions: active 0..399, front 400..403, sync 404..407, back 408..419.
//   vsync is asserted for whole lines 404..407.
//  de_raw = h_active && v_active.
//  rd_addr (combinational from registered counters):
//   increments by 1 on each de_raw cycle.
//   Holds its value outside active pixels (end of line N is 640N+639, next line starts at 640(N+1)).
//   Resets to 0 at v_cnt wrap. Never exceeds 255999.
//  Sync and de pass through a RD_LATENCY-deep shift register so the pins align with color:
//   hsync/vsync/data change exactly RD_LATENCY+1 clocks after the counter state that produced them (one output register).
//  Data output: when delayed de=1, {y,cr,cb} <= color; otherwise {y,cr,cb} <= 0 (black in blanking).
//  clock_out: 0 while !running; otherwise toggles with clk, inverted relative to clk.
//   Panel samples data on the clock_out rising edge, mid-data-eye. Implemented as a registered DDR-style output or ~clk gated by running.
//  Ready drop mid-frame: current frame completes.
//   At v_cnt wrap running clears, counters hold 0, outputs return to reset values.
//   Scan restarts at the next ready=1.
//  Ready glitch high for one cycle: start is committed; a full frame is emitted.
//  Mid-scan reset: immediate async return to reset values; no partial-frame recovery.
// STRUCTURE
//  Package display_pkg: timing localparams, region boundaries, and a {y,cr,cb} packed struct typedef.
//   color_table shares the struct typedef.
//  Sub-module display_timing: h/v counters, region decode, running flag, rd_addr.
//  Top level holds the latency pipeline and the output registers.
// TESTING
//  Reset held, ready=0 for 1000 clk -> hsync=vsync=1, y/cr/cb=0, rd_addr=0, clock_out=0 throughout.
//  ready rises at T -> first hsync low at T+1+664+RD_LATENCY+1 clocks, lasting 32 clocks.
//   Period is 800 clocks; vsync low for 3200 clocks every 336000.
//  Address sweep -> rd_addr 0..639 on line 0, 640 on line 1 pixel 0, 255999 on the last pixel, 0 again next frame.
//  color = rd_addr[9:0] model, delayed by 2 -> {y,cr,cb} equals the expected code at every de pixel and 0 in blanking.
//  ready dropped at line 200 -> frame completes to line 419, then outputs idle.
//   ready re-asserted -> new frame starts from rd_addr=0.
//  reset_n pulsed low mid-line -> outputs take reset values asynchronously; restart requires ready.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and pixel/timing types for the micro-display path.
// Default raster geometry is the 640x400 panel mode.
package display_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 24;
    localparam int H_SYNC   = 32;
    localparam int H_BACK   = 104;

    localparam int V_ACTIVE = 400;
    localparam int V_FRONT  = 4;
    localparam int V_SYNC   = 4;
    localparam int V_BACK   = 12;

    localparam int   RD_LATENCY   = 2;
    localparam logic SYNC_ACT_LOW = 1'b1;
    localparam int   ADDR_W       = 18;

    typedef struct packed {
        logic [3:0] y;
        logic [2:0] cr;
        logic [2:0] cb;
    } pix_t;

    // Raw timing flags, active-high, before pin polarity is applied
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } tsig_t;

endpackage

// File: rtl/display_if.sv
// Frame-buffer read port plus panel pins of the display driver.
// master = driver side, slave = memory/panel side.
interface display_if;
    import display_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    pix_t              color;
    logic              clock_out;
    logic              hsync;
    logic              vsync;
    logic [3:0]        y;
    logic [2:0]        cr;
    logic [2:0]        cb;

    modport master (
        output rd_addr, clock_out, hsync, vsync, y, cr, cb,
        input  color
    );

    modport slave (
        input  rd_addr, clock_out, hsync, vsync, y, cr, cb,
        output color
    );

endinterface

// File: rtl/display_timing.sv
// Raster counters, region decode, run control and frame-buffer address.
// rd_addr is combinational from the registered counters.
module display_timing
    import display_pkg::*;
#(
    parameter int H_ACT = display_pkg::H_ACTIVE,
    parameter int H_FP  = display_pkg::H_FRONT,
    parameter int H_SW  = display_pkg::H_SYNC,
    parameter int H_BP  = display_pkg::H_BACK,
    parameter int V_ACT = display_pkg::V_ACTIVE,
    parameter int V_FP  = display_pkg::V_FRONT,
    parameter int V_SW  = display_pkg::V_SYNC,
    parameter int V_BP  = display_pkg::V_BACK
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready,
    output logic              running,
    output tsig_t             tsig,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_AEND = HW'(H_ACT);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SW);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_AEND = VW'(V_ACT);
    localparam logic [VW-1:0] V_ALST = VW'(V_ACT - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SW);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACT);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(H_ACT - 1);

    logic              running_q, running_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              h_last, v_last, frame_end;

    // Next-state: counters advance while running; the line base
    // steps by one row per active line and freezes on the last row
    always_comb begin
        h_last    = (h_cnt_q == H_LAST);
        v_last    = (v_cnt_q == V_LAST);
        frame_end = running_q & h_last & v_last;
        running_d = running_q ? ~(frame_end & ~ready) : ready;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        base_d    = base_q;
        if (running_q) begin
            if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d = '0;
                    base_d  = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                    if (v_cnt_q < V_ALST) begin
                        base_d = base_q + LINE_STEP;
                    end
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Region decode and address; outside active pixels the address
    // holds the last pixel of the current row
    always_comb begin
        tsig.de = running_q & (h_cnt_q < H_AEND) & (v_cnt_q < V_AEND);
        tsig.hs = running_q & (h_cnt_q >= HS_BEG) & (h_cnt_q < HS_END);
        tsig.vs = running_q & (v_cnt_q >= VS_BEG) & (v_cnt_q < VS_END);
        rd_addr = '0;
        if (running_q) begin
            rd_addr = base_q + (tsig.de ? ADDR_W'(h_cnt_q) : PIX_LAST);
        end
    end

    // Counter and run-state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_q <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            base_q    <= '0;
        end else begin
            running_q <= running_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            base_q    <= base_d;
        end
    end

    assign running = running_q;

endmodule

// File: rtl/display_driver.sv
// Display driver top: timing core, sync/de delay line matching the
// frame-buffer + colour-table latency, and the panel output registers.
module display_driver
    import display_pkg::*;
#(
    parameter int H_ACT = display_pkg::H_ACTIVE,
    parameter int H_FP  = display_pkg::H_FRONT,
    parameter int H_SW  = display_pkg::H_SYNC,
    parameter int H_BP  = display_pkg::H_BACK,
    parameter int V_ACT = display_pkg::V_ACTIVE,
    parameter int V_FP  = display_pkg::V_FRONT,
    parameter int V_SW  = display_pkg::V_SYNC,
    parameter int V_BP  = display_pkg::V_BACK
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      ready,
    display_if.master bus
);

    logic              running;
    tsig_t             tsig;
    logic [ADDR_W-1:0] rd_addr;

    display_timing #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk     (clk),
        .reset_n (reset_n),
        .ready   (ready),
        .running (running),
        .tsig    (tsig),
        .rd_addr (rd_addr)
    );

    assign bus.rd_addr = rd_addr;

    tsig_t pipe_q [RD_LATENCY];
    tsig_t pipe_d [RD_LATENCY];
    tsig_t tap;
    logic  hsync_q, hsync_d;
    logic  vsync_q, vsync_d;
    pix_t  pix_q, pix_d;

    // Delay line so timing flags arrive with the colour they addressed
    always_comb begin
        pipe_d[0] = tsig;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Delay-line registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tap = pipe_q[RD_LATENCY-1];

    // Pin values: polarity-adjusted syncs, black during blanking
    always_comb begin
        hsync_d = tap.hs ^ SYNC_ACT_LOW;
        vsync_d = tap.vs ^ SYNC_ACT_LOW;
        pix_d   = tap.de ? bus.color : '0;
    end

    // Output registers; reset to inactive sync level and black
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= SYNC_ACT_LOW;
            vsync_q <= SYNC_ACT_LOW;
            pix_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            pix_q   <= pix_d;
        end
    end

    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.y     = pix_q.y;
    assign bus.cr    = pix_q.cr;
    assign bus.cb    = pix_q.cb;

    // Inverted clock puts the panel's rising edge mid-data-eye
    assign bus.clock_out = running & ~clk;

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: full-size and shrunken-raster instances
// against a position-based raster model, plus directed sequences.
module tb_display_driver;
    import display_pkg::*;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic ready;

    always #5 clk = ~clk;

    display_if bus_f();
    display_if bus_s();

    display_driver dut_f (
        .clk     (clk),
        .reset_n (reset_n),
        .ready   (ready),
        .bus     (bus_f)
    );

    display_driver #(
        .H_ACT(16), .H_FP(4), .H_SW(8), .H_BP(12),
        .V_ACT(6),  .V_FP(2), .V_SW(2), .V_BP(4)
    ) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .ready   (ready),
        .bus     (bus_s)
    );

    // Frame buffer + colour table: two registered reads, code = addr[9:0]
    logic [9:0] fb_f, fb_s;
    always @(posedge clk) begin
        fb_f      <= bus_f.rd_addr[9:0];
        fb_s      <= bus_s.rd_addr[9:0];
        bus_f.color <= pix_t'(fb_f);
        bus_s.color <= pix_t'(fb_s);
    end

    int g_hact[NI], g_hfp[NI], g_hsw[NI], g_hbp[NI];
    int g_vact[NI], g_vfp[NI], g_vsw[NI], g_vbp[NI];

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [9:0] code;
    } pin_t;

    localparam pin_t IDLE = '{hs: 1'b1, vs: 1'b1, code: 10'd0};

    int          pos[NI];
    int          pix[NI];
    pin_t        hist[NI][3];
    pin_t        exp_pin[NI];
    logic [17:0] exp_ad[NI];

    int n_err = 0;
    int n_chk = 0;

    function automatic int htot(int i);
        return g_hact[i] + g_hfp[i] + g_hsw[i] + g_hbp[i];
    endfunction

    function automatic int ftot(int i);
        return htot(i) * (g_vact[i] + g_vfp[i] + g_vsw[i] + g_vbp[i]);
    endfunction

    function automatic bit pos_de(int i, int p);
        if (p < 0) return 1'b0;
        return ((p % htot(i)) < g_hact[i]) && ((p / htot(i)) < g_vact[i]);
    endfunction

    function automatic int addr_now(int i);
        if (pos[i] < 0) return 0;
        if (pos_de(i, pos[i])) return pix[i];
        return (pix[i] == 0) ? 0 : pix[i] - 1;
    endfunction

    function automatic pin_t pin_now(int i);
        pin_t r;
        int h, v, a;
        r = IDLE;
        if (pos[i] >= 0) begin
            h = pos[i] % htot(i);
            v = pos[i] / htot(i);
            a = addr_now(i);
            r.hs = !(h >= g_hact[i] + g_hfp[i] &&
                     h <  g_hact[i] + g_hfp[i] + g_hsw[i]);
            r.vs = !(v >= g_vact[i] + g_vfp[i] &&
                     v <  g_vact[i] + g_vfp[i] + g_vsw[i]);
            r.code = pos_de(i, pos[i]) ? 10'(a) : 10'd0;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            pos[i] = -1;
            pix[i] = 0;
            for (int k = 0; k < 3; k++) hist[i][k] = IDLE;
            exp_pin[i] = IDLE;
            exp_ad[i]  = '0;
        end
    endtask

    // One clock of the raster: a frame is just a linear position
    task automatic model_step(input logic r);
        for (int i = 0; i < NI; i++) begin
            if (pos[i] < 0) begin
                if (r) begin
                    pos[i] = 0;
                    pix[i] = 0;
                end
            end else begin
                if (pos_de(i, pos[i])) pix[i]++;
                pos[i]++;
                if (pos[i] == ftot(i)) begin
                    pos[i] = r ? 0 : -1;
                    pix[i] = 0;
                end
            end
            exp_pin[i] = hist[i][0];
            hist[i][0] = hist[i][1];
            hist[i][1] = hist[i][2];
            hist[i][2] = pin_now(i);
            exp_ad[i]  = 18'(addr_now(i));
        end
    endtask

    function automatic logic [31:0] act_word(int i);
        if (i == 0)
            return {1'b0, bus_f.rd_addr, bus_f.hsync, bus_f.vsync,
                    bus_f.y, bus_f.cr, bus_f.cb, bus_f.clock_out};
        return {1'b0, bus_s.rd_addr, bus_s.hsync, bus_s.vsync,
                bus_s.y, bus_s.cr, bus_s.cb, bus_s.clock_out};
    endfunction

    function automatic logic [31:0] exp_word(int i, logic co);
        return {1'b0, exp_ad[i], exp_pin[i].hs, exp_pin[i].vs,
                exp_pin[i].code, co};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model update, pins after the edge, clock_out mid-cycle
    task automatic step();
        logic r;
        r = ready;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(r);
        #1;
        check("pins_f", act_word(0), exp_word(0, 1'b0));
        check("pins_s", act_word(1), exp_word(1, 1'b0));
        @(negedge clk);
        #1;
        check_int("clkout_f", int'(bus_f.clock_out), int'(pos[0] >= 0));
        check_int("clkout_s", int'(bus_s.clock_out), int'(pos[1] >= 0));
    endtask

    // Asynchronous reset pulse in the low clock phase
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_f", act_word(0), exp_word(0, 1'b0));
        check("arst_s", act_word(1), exp_word(1, 1'b0));
        step();
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        int          n;
        logic [17:0] addr;
        logic        hs;
        logic [9:0]  code;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int fall1, rise1, fall2, cnt, maxa;
        logic prev;
        bit found;

        g_hact = '{640, 16}; g_hfp = '{24, 4}; g_hsw = '{32, 8}; g_hbp = '{104, 12};
        g_vact = '{400, 6};  g_vfp = '{4, 2};  g_vsw = '{4, 2};  g_vbp = '{12, 4};

        // n = clocks after the start edge: {n, rd_addr, hsync, code}
        vecs.push_back('{0,    18'd0,    1'b1, 10'd0});
        vecs.push_back('{4,    18'd4,    1'b1, 10'd1});
        vecs.push_back('{642,  18'd639,  1'b1, 10'd639});
        vecs.push_back('{643,  18'd639,  1'b1, 10'd0});
        vecs.push_back('{666,  18'd639,  1'b1, 10'd0});
        vecs.push_back('{667,  18'd639,  1'b0, 10'd0});
        vecs.push_back('{698,  18'd639,  1'b0, 10'd0});
        vecs.push_back('{699,  18'd639,  1'b1, 10'd0});
        vecs.push_back('{800,  18'd640,  1'b1, 10'd0});
        vecs.push_back('{803,  18'd643,  1'b1, 10'd640});
        vecs.push_back('{1442, 18'd1279, 1'b1, 10'd255});
        vecs.push_back('{1467, 18'd1279, 1'b0, 10'd0});
        vecs.push_back('{1600, 18'd1280, 1'b1, 10'd0});

        ready   = 1'b0;
        reset_n = 1'b0;
        fb_f = '0; fb_s = '0;
        bus_f.color = '0; bus_s.color = '0;
        model_reset();

        // Reset held with ready low
        for (int c = 0; c < 1000; c++) step();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // One-cycle ready glitch: full-size line checks, small frame count
        ready = 1'b1;
        cnt = 0;
        for (int n = 0; n <= 1700; n++) begin
            step();
            if (n == 0) ready = 1'b0;
            if (bus_s.clock_out) cnt++;
            foreach (vecs[k]) begin
                if (vecs[k].n == n) begin
                    check("vec", {bus_f.rd_addr, bus_f.hsync, bus_f.y, bus_f.cr, bus_f.cb},
                          {vecs[k].addr, vecs[k].hs, vecs[k].code});
                end
            end
        end
        check_int("glitch_frame_len", cnt, 560);

        // Continuous scan on the small raster: vsync width/period
        ready = 1'b1;
        fall1 = -1; rise1 = -1; fall2 = -1; maxa = 0;
        prev = bus_s.vsync;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (int'(bus_s.rd_addr) > maxa) maxa = int'(bus_s.rd_addr);
            if (prev && !bus_s.vsync) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!prev && bus_s.vsync && fall1 >= 0 && rise1 < 0) rise1 = k;
            prev = bus_s.vsync;
        end
        check_int("vsync_width", rise1 - fall1, 80);
        check_int("vsync_period", fall2 - fall1, 560);
        check_int("last_addr", maxa, 95);

        // Drop ready at line 3: frame completes, then idles
        found = 1'b0;
        for (int k = 0; k < 1200 && !found; k++) begin
            step();
            if (bus_s.rd_addr == 18'd48) found = 1'b1;
        end
        check_int("line3_found", int'(found), 1);
        ready = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            step();
            cnt++;
            if (!bus_s.clock_out) found = 1'b1;
        end
        check_int("drop_to_idle", cnt, 440);
        ready = 1'b1;
        step();
        check("restart", {bus_s.rd_addr, bus_s.clock_out}, {18'd0, 1'b1});

        // Random ready activity with asynchronous resets
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(299) == 0) ready = ~ready;
            if (c == 5000 || $urandom_range(5999) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
